btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- IF queries it every cycle with the fetch PC and receives the predicted next PC.
- EX sends one resolution per cycle for control instructions; the table is trained on those resolutions.
- This block is the responder to EX's prediction, jump-resolution and BTB-change outputs; it sits between IF (lookup) and EX (update).

Parameters:
- ADDR_LEN, 32, PC/target width.
- INDEX_BITS, 6, log2 of entry count (64 entries).
- TAG_BITS, ADDR_LEN-INDEX_BITS-2, stored tag width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high (`ResetEnable` = 1'b1).
- if_pc  in  ADDR_LEN  fetch PC to look up.
- prediction  out  ADDR_LEN  predicted next PC for if_pc.
- pred_taken  out  1  prediction is a taken branch/jump.
- upd_enable  in  1  EX resolved a control instruction this cycle.
- upd_pc  in  ADDR_LEN  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_uncond  in  1  resolved instruction is JAL (always taken).
- upd_target  in  ADDR_LEN  resolved taken target.
- upd_mispredict  in  1  EX flagged a misprediction (jmp_enable).
- mispredict_cnt  out  32  performance counter of mispredictions.

Behaviour:
- Index = pc[INDEX_BITS+1:2]; tag = pc[ADDR_LEN-1:INDEX_BITS+2]; the 2 LSBs are ignored.
- Storage per entry: valid, tag, target, cnt[1:0]. Only valid and cnt are reset; tag and target are not.
- Lookup (combinational from registered state):
  - hit = valid[idx] && tag matches.
  - pred_taken = hit && cnt[idx][1].
  - prediction = pred_taken ? target[idx] : if_pc+4. The +4 wraps modulo 2^ADDR_LEN.
- Lookup is read-before-write. A same-cycle update to the same index is not visible until the next cycle; there is no bypass.
- Update happens at posedge clk when upd_enable=1 and rst=0.
  - Hit, upd_uncond=1: cnt=2'b11, target=upd_target.
  - Hit, taken: cnt saturating +1 (caps at 2'b11), target=upd_target.
  - Hit, not taken: cnt saturating −1 (floors at 2'b00). Target unchanged; valid stays 1.
  - Miss, taken or uncond: allocate and overwrite any alias.
    - valid=1, tag=upd tag, target=upd_target.
    - cnt=2'b11 if uncond, else 2'b10.
  - Miss, not taken: no change; no allocation.
- mispredict_cnt increments by 1 at posedge when upd_enable && upd_mispredict. It wraps 0xFFFFFFFF→0.
- upd_mispredict without upd_enable is ignored.
- Reset (synchronous, one cycle):
  - All valid←0, all cnt←2'b01, mispredict_cnt←0.
  - While rst=1: pred_taken=0 and prediction=if_pc+4, regardless of table state.
  - An update presented during rst is dropped.
  - Reset mid-training leaves no partial entry.
- Latency: one cycle from update to visible effect at lookup.

Decomposition:
- Shared defines/package: AddrLen, ResetEnable, ZERO_WORD, BTB index/tag widths, counter encodings (CNT_SNT=00, CNT_WNT=01, CNT_WT=10, CNT_ST=11).
- One natural sub-module: btb_sat_counter, a 2-bit saturating next-state function with inc/dec/force-strong inputs. The table and perf counter stay in the top.

Test Plan:
- Reset, then lookup if_pc=0x1000 → prediction=0x1004, pred_taken=0; mispredict_cnt=0.
- Update pc=0x1000, taken, target=0x2000; next cycle lookup 0x1000 → prediction=0x2000, pred_taken=1 (cnt=10).
- Same entry:
  - Two not-taken updates → cnt 10→01→00; lookup → 0x1004.
  - Then three taken updates → cnt saturates at 11.
- Alias: after training 0x1000→0x2000, lookup 0x1100 (same index, different tag) → 0x1104, taken=0.
  - Then JAL update pc=0x1100, target=0x3000 → 0x1100 predicts 0x3000; 0x1000 now misses → 0x1004.
- Same cycle: lookup 0x1000 while first taken update to 0x1000 → that cycle 0x1004, next cycle 0x2000.
- Reset during activity:
  - Assert rst with entries valid and upd_enable=1 → update dropped; all lookups →pc+4; mispredict_cnt=0.
  - 5 mispredict updates → mispredict_cnt=5.

Source files
------------

// File: rtl/btb_predictor_pkg.sv
// Shared widths, reset polarity and direction-counter encodings for the BTB predictor.
package btb_predictor_pkg;

    localparam int unsigned AddrLen     = 32;
    localparam logic        ResetEnable = 1'b1;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    localparam int unsigned IndexBits = 6;
    localparam int unsigned TagBits   = AddrLen - IndexBits - 2;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state function of a 2-bit saturating direction counter.
module btb_sat_counter
    import btb_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    input  logic       dec,
    input  logic       force_strong,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (force_strong) begin
            cnt_next = CNT_ST;
        end else if (inc) begin
            if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
        end else if (dec) begin
            if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: IF lookup, EX-driven training,
// and a misprediction performance counter.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int unsigned ADDR_LEN   = AddrLen,
    parameter int unsigned INDEX_BITS = IndexBits,
    parameter int unsigned TAG_BITS   = ADDR_LEN - INDEX_BITS - 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] if_pc,
    output logic [ADDR_LEN-1:0] prediction,
    output logic                pred_taken,
    input  logic                upd_enable,
    input  logic [ADDR_LEN-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic                upd_uncond,
    input  logic [ADDR_LEN-1:0] upd_target,
    input  logic                upd_mispredict,
    output logic [31:0]         mispredict_cnt
);

    localparam int unsigned Entries = 1 << INDEX_BITS;
    localparam logic [ADDR_LEN-1:0] PcStep = ADDR_LEN'(4);

    logic                valid_q  [Entries];
    logic [1:0]          cnt_q    [Entries];
    logic [TAG_BITS-1:0] tag_q    [Entries];
    logic [ADDR_LEN-1:0] target_q [Entries];
    logic [31:0]         mispredict_cnt_q;

    logic [INDEX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_BITS-1:0]   if_tag, upd_tag;
    logic                  lookup_hit, upd_hit, upd_redirect, upd_alloc;
    logic [1:0]            cnt_trained;
    logic                  unused_pc_lsbs;

    assign if_idx  = if_pc[INDEX_BITS+1:2];
    assign if_tag  = if_pc[ADDR_LEN-1:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[ADDR_LEN-1:INDEX_BITS+2];
    assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

    // Lookup reads only registered state, so a same-cycle update is seen next cycle.
    assign lookup_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    always_comb begin
        pred_taken = 1'b0;
        prediction = if_pc + PcStep;
        if (rst != ResetEnable && lookup_hit && cnt_q[if_idx][1]) begin
            pred_taken = 1'b1;
            prediction = target_q[if_idx];
        end
    end

    assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_redirect = upd_taken || upd_uncond;
    assign upd_alloc    = !upd_hit && upd_redirect;

    btb_sat_counter u_sat_counter (
        .cnt          (cnt_q[upd_idx]),
        .inc          (upd_taken),
        .dec          (!upd_taken),
        .force_strong (upd_uncond),
        .cnt_next     (cnt_trained)
    );

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            for (int i = 0; i < Entries; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
            mispredict_cnt_q <= ZERO_WORD;
        end else if (upd_enable) begin
            if (upd_hit) begin
                cnt_q[upd_idx] <= cnt_trained;
            end else if (upd_alloc) begin
                valid_q[upd_idx] <= 1'b1;
                cnt_q[upd_idx]   <= upd_uncond ? CNT_ST : CNT_WT;
            end
            if (upd_mispredict) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
        end
    end

    // Tag and target carry no reset; a cleared valid bit makes them don't-care.
    always_ff @(posedge clk) begin
        if (rst != ResetEnable && upd_enable) begin
            if (upd_alloc) tag_q[upd_idx] <= upd_tag;
            if (upd_redirect) target_q[upd_idx] <= upd_target;
        end
    end

    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: a behavioural table model queues expectations per cycle.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] prediction;
    logic        pred_taken;
    logic        upd_enable;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_uncond;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] mispredict_cnt;

    btb_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .prediction     (prediction),
        .pred_taken     (pred_taken),
        .upd_enable     (upd_enable),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_uncond     (upd_uncond),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pred;
        logic        taken;
        logic [31:0] mis;
        bit          mis_known;
        bit          directed;
        logic [31:0] d_pred;
        logic        d_taken;
    } exp_t;

    exp_t sb_q[$];

    int n_compared = 0;
    int n_mismatch = 0;

    // Independent behavioural model of the table.
    bit          m_valid  [64];
    logic [23:0] m_tag    [64];
    logic [31:0] m_target [64];
    logic [1:0]  m_cnt    [64];
    logic [31:0] m_mis;
    bit          m_mis_known = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] pc, input logic ue,
                        input logic [31:0] upc, input logic ut, input logic uu,
                        input logic [31:0] utgt, input logic um, input bit dir,
                        input logic [31:0] d_pred, input logic d_taken);
        exp_t e;
        exp_t got;
        int   i;
        bit   hit;
        rst = r; if_pc = pc; upd_enable = ue; upd_pc = upc; upd_taken = ut;
        upd_uncond = uu; upd_target = utgt; upd_mispredict = um;
        i = int'(pc[7:2]);
        hit = m_valid[i] && (m_tag[i] == pc[31:8]);
        e.taken = !r && hit && m_cnt[i][1];
        e.pred = e.taken ? m_target[i] : pc + 32'd4;
        e.mis = m_mis; e.mis_known = m_mis_known;
        e.directed = dir; e.d_pred = d_pred; e.d_taken = d_taken;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        check_eq("pred", {32'd0, prediction}, {32'd0, got.pred});
        check_eq("taken", {63'd0, pred_taken}, {63'd0, got.taken});
        if (got.mis_known) check_eq("mis_cnt", {32'd0, mispredict_cnt}, {32'd0, got.mis});
        if (got.directed) begin
            check_eq("plan_pred", {32'd0, prediction}, {32'd0, got.d_pred});
            check_eq("plan_taken", {63'd0, pred_taken}, {63'd0, got.d_taken});
        end
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 0;
                m_cnt[k] = 2'b01;
            end
            m_mis = 32'd0;
            m_mis_known = 1;
        end else if (ue) begin
            i = int'(upc[7:2]);
            hit = m_valid[i] && (m_tag[i] == upc[31:8]);
            if (hit) begin
                if (uu) m_cnt[i] = 2'b11;
                else if (ut && m_cnt[i] != 2'b11) m_cnt[i] = m_cnt[i] + 2'd1;
                else if (!ut && m_cnt[i] != 2'b00) m_cnt[i] = m_cnt[i] - 2'd1;
                if (ut || uu) m_target[i] = utgt;
            end else if (ut || uu) begin
                m_valid[i] = 1;
                m_tag[i] = upc[31:8];
                m_target[i] = utgt;
                m_cnt[i] = uu ? 2'b11 : 2'b10;
            end
            if (um) m_mis = m_mis + 32'd1;
        end
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input logic [31:0] d_pred, input logic d_taken);
        step(1'b0, pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, d_pred, d_taken);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] upc, input logic ut,
                         input logic uu, input logic [31:0] utgt, input logic um,
                         input logic [31:0] d_pred, input logic d_taken);
        step(1'b0, pc, 1'b1, upc, ut, uu, utgt, um, 1'b1, d_pred, d_taken);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) m_valid[k] = 0;
        @(posedge clk); #1;
        // Reset with a dropped update, then the basic taken path.
        step(1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b1, 32'h1004, 1'b0);
        look(32'h1000, 32'h1004, 1'b0);
        check_eq("mis_after_reset", {32'd0, mispredict_cnt}, 64'd0);
        train(32'h1000, 32'h1000, 1'b1, 1'b0, 32'h2000, 1'b0, 32'h1004, 1'b0);
        look(32'h1000, 32'h2000, 1'b1);
        // Two not-taken: 10 -> 01 -> 00.
        train(32'h1000, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2000, 1'b1);
        train(32'h1000, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1004, 1'b0);
        look(32'h1000, 32'h1004, 1'b0);
        // Three taken saturate at 11; one not-taken must still predict taken.
        train(32'h1000, 32'h1000, 1'b1, 1'b0, 32'h2000, 1'b0, 32'h1004, 1'b0);
        train(32'h1000, 32'h1000, 1'b1, 1'b0, 32'h2000, 1'b0, 32'h1004, 1'b0);
        train(32'h1000, 32'h1000, 1'b1, 1'b0, 32'h2000, 1'b0, 32'h2000, 1'b1);
        train(32'h1000, 32'h1000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2000, 1'b1);
        look(32'h1000, 32'h2000, 1'b1);
        // Alias on the same index, then JAL takes over the entry.
        look(32'h1100, 32'h1104, 1'b0);
        train(32'h1100, 32'h1100, 1'b0, 1'b1, 32'h3000, 1'b1, 32'h1104, 1'b0);
        look(32'h1100, 32'h3000, 1'b1);
        look(32'h1000, 32'h1004, 1'b0);
        // Miss not-taken must not allocate; mispredict without enable is ignored.
        train(32'h1200, 32'h1200, 1'b0, 1'b0, 32'h4000, 1'b0, 32'h1204, 1'b0);
        step(1'b0, 32'h1200, 1'b0, 32'h1200, 1'b1, 1'b0, 32'h4000, 1'b1, 1'b1, 32'h1204, 1'b0);
        look(32'h1100, 32'h3000, 1'b1);
        check_eq("mis_one", {32'd0, mispredict_cnt}, 64'd1);
        look(32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
        // Reset during activity with an update pending.
        step(1'b1, 32'h1100, 1'b1, 32'h1100, 1'b1, 1'b0, 32'h5000, 1'b1, 1'b1, 32'h1104, 1'b0);
        look(32'h1100, 32'h1104, 1'b0);
        look(32'h1000, 32'h1004, 1'b0);
        check_eq("mis_cleared", {32'd0, mispredict_cnt}, 64'd0);
        for (int n = 0; n < 5; n++)
            train(32'h1300, 32'h1300, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1304, 1'b0);
        check_eq("mis_five", {32'd0, mispredict_cnt}, 64'd5);
        // Random traffic over a few aliasing PCs, checked against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] rpc, upc_r;
            rpc   = {20'h0, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), 6'd0} | 32'h1000;
            upc_r = {20'h0, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), 6'd0} | 32'h1000;
            step(($urandom_range(0, 49) == 0), rpc, 1'($urandom), upc_r, 1'($urandom),
                 ($urandom_range(0, 5) == 0), $urandom & 32'hFFFF_FFFC, 1'($urandom),
                 1'b0, 32'h0, 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
